// File: rtl/nibble_packer_pkg.sv
// rtl/nibble_packer_pkg.sv - shared types and constants for the nibble packer
//
// Purpose: state encoding, item width and default packing factor shared by
//          the packer and anything that instantiates it.
// Ports:   none (package).
package nibble_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  localparam int ITEM_W          = 4;
  localparam int DEFAULT_NIBBLES = 4;

endpackage

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs 4-bit items into NIBBLES-wide output words
//
// Purpose: accepts one 4-bit item per cycle from an upstream queue, packs
//          them little-end first into a word, and presents the word (full,
//          or partial on flush) to a downstream consumer with a count.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   in_valid   - upstream item present (queue deq_valid)
//   in_data    - upstream item (queue dout)
//   in_ready   - item accepted this cycle (queue deq), registered
//   flush      - emit a partially filled word
//   out_valid  - packed word available
//   out_data   - packed word, first item in bits [3:0]
//   out_count  - number of valid items in out_data
//   out_ready  - downstream takes the word this cycle
//   words      - number of words emitted, wraps at 256
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [ITEM_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [ITEM_W*NIBBLES-1:0]  out_data,
  output logic [3:0]                 out_count,
  input  logic                       out_ready,
  output logic [7:0]                 words
);

  localparam int         DATA_W   = ITEM_W * NIBBLES;
  localparam logic [2:0] CNT_LAST = 3'(NIBBLES - 1);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [3:0]          out_count_q, out_count_d;
  logic [7:0]          words_q, words_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                accept;

  // in_ready_q is only ever set in FILL, so this is also the FILL qualifier.
  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    out_count_d = out_count_q;
    words_d     = words_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FILL;
        in_ready_d = 1'b1;
      end

      ST_FILL: begin
        if (accept) begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (cnt_q == 3'(k)) data_d[k*ITEM_W +: ITEM_W] = in_data;
          end
          // A flush alongside an accept closes the word including this item.
          if (cnt_q == CNT_LAST || flush) begin
            state_d     = ST_EMIT;
            out_count_d = {1'b0, cnt_q} + 4'd1;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (flush && cnt_q != 3'd0) begin
          state_d     = ST_EMIT;
          out_count_d = {1'b0, cnt_q};
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
        end
      end

      ST_EMIT: begin
        if (out_ready) begin
          state_d     = ST_FILL;
          cnt_d       = 3'd0;
          data_d      = '0;
          out_count_d = 4'd0;
          words_d     = words_q + 8'd1;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      data_q      <= '0;
      out_count_q <= 4'd0;
      words_q     <= 8'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      out_count_q <= out_count_d;
      words_q     <= words_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign out_count = out_count_q;
  assign words     = words_q;

endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - directed self-checking bench for nibble_packer
module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_count;
  logic        out_ready;
  logic [7:0]  words;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nibble_packer #(.NIBBLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ready (out_ready),
    .words     (words)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] item(input int i);
    return 4'(i * 7 + 3);
  endfunction

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 4'hF; flush = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 16'h0) begin miscompares++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    vectors++; if (out_count !== 4'd0) begin miscompares++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
    vectors++; if (words !== 8'd0) begin miscompares++; $display("FAIL rst_words: got %0d want 0", words); end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL release_in_ready_early: got %b want 0", in_ready); end
    step();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_full_word();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      step();
      if (i < 4) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fill_out_valid[%0d]: got %b want 0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
    vectors++; if (out_data !== 16'h4321) begin miscompares++; $display("FAIL full_out_data: got %h want 4321", out_data); end
    vectors++; if (out_count !== 4'd4) begin miscompares++; $display("FAIL full_out_count: got %0d want 4", out_count); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b0; flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (out_data !== 16'h4321) begin miscompares++; $display("FAIL hold_out_data[%0d]: got %h want 4321", i, out_data); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_out_valid[%0d]: got %b want 1", i, out_valid); end
      vectors++; if (out_count !== 4'd4) begin miscompares++; $display("FAIL hold_out_count[%0d]: got %0d want 4", i, out_count); end
    end
    flush = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++; if (words !== 8'd1) begin miscompares++; $display("FAIL drain_words: got %0d want 1", words); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL drain_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 16'h0) begin miscompares++; $display("FAIL drain_out_data: got %h want 0000", out_data); end
  endtask

  task automatic test_flush_partial();
    in_valid = 1'b1; in_data = 4'hA; step();
    in_data = 4'hB; step();
    in_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL flush2_out_valid: got %b want 1", out_valid); end
    vectors++; if (out_data !== 16'h00BA) begin miscompares++; $display("FAIL flush2_out_data: got %h want 00ba", out_data); end
    vectors++; if (out_count !== 4'd2) begin miscompares++; $display("FAIL flush2_out_count: got %0d want 2", out_count); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    vectors++; if (words !== 8'd2) begin miscompares++; $display("FAIL flush2_words: got %0d want 2", words); end
  endtask

  task automatic test_flush_with_accept();
    flush = 1'b1; in_valid = 1'b0; step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_empty_out_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_empty_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b1; in_data = 4'h5; step();
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL flush1_out_valid: got %b want 1", out_valid); end
    vectors++; if (out_data !== 16'h0005) begin miscompares++; $display("FAIL flush1_out_data: got %h want 0005", out_data); end
    vectors++; if (out_count !== 4'd1) begin miscompares++; $display("FAIL flush1_out_count: got %0d want 1", out_count); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    vectors++; if (words !== 8'd3) begin miscompares++; $display("FAIL flush1_words: got %0d want 3", words); end
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 4'(i); step();
    end
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL async_rst_in_ready: got %b want 0", in_ready); end
    vectors++; if (out_data !== 16'h0) begin miscompares++; $display("FAIL async_rst_out_data: got %h want 0000", out_data); end
    vectors++; if (words !== 8'd0) begin miscompares++; $display("FAIL async_rst_words: got %0d want 0", words); end
    in_valid = 1'b1; in_data = 4'hC;
    step(); step();
    vectors++; if (out_data !== 16'h0) begin miscompares++; $display("FAIL rst_no_accept: got %h want 0000", out_data); end
    in_valid = 1'b0; reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'(7 + i); step();
      if (i < 3) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL refill_out_valid[%0d]: got %b want 0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    vectors++; if (out_data !== 16'hA987) begin miscompares++; $display("FAIL refill_out_data: got %h want a987", out_data); end
    vectors++; if (out_count !== 4'd4) begin miscompares++; $display("FAIL refill_out_count: got %0d want 4", out_count); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    vectors++; if (words !== 8'd1) begin miscompares++; $display("FAIL refill_words: got %0d want 1", words); end
  endtask

  task automatic test_stream_wrap();
    int          sent;
    int          w;
    int          cyc;
    logic        acc;
    logic [15:0] exp_word;
    reset = 1'b0; step(); reset = 1'b1; step();
    out_ready = 1'b1; in_valid = 1'b1;
    sent = 0; w = 0; cyc = 0;
    in_data = item(0);
    while (w < 256 && cyc < 2000) begin
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        sent++;
        in_data = item(sent);
      end
      if (out_valid === 1'b1) begin
        for (int j = 0; j < 4; j++) exp_word[4*j +: 4] = item(4 * w + j);
        vectors++; if (out_data !== exp_word) begin miscompares++; $display("FAIL stream_word[%0d]: got %h want %h", w, out_data, exp_word); end
        if (w == 255) begin
          vectors++; if (cyc !== 1279) begin miscompares++; $display("FAIL stream_rate: got cycle %0d want 1279", cyc); end
        end
        w++;
      end
    end
    in_valid = 1'b0;
    vectors++; if (w !== 256) begin miscompares++; $display("FAIL stream_count: got %0d words want 256", w); end
    step();
    out_ready = 1'b0;
    vectors++; if (words !== 8'd0) begin miscompares++; $display("FAIL stream_wrap_words: got %0d want 0", words); end
    vectors++; if (sent !== 1024) begin miscompares++; $display("FAIL stream_items: got %0d want 1024", sent); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_word();
    test_backpressure();
    test_flush_partial();
    test_flush_with_accept();
    test_reset_mid_fill();
    test_stream_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 Parameter: NIBBLES, default 4; number of 4-bit items packed per output word (legal 2..8).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream item available; driven by queue deq_valid.
REQ-005 in_data  input  4  upstream item; driven by queue dout.
REQ-006 in_ready  output  1  packer accepts the item this cycle; drives queue deq.
REQ-007 flush  input  1  request to emit a partially filled word.
REQ-008 out_valid  output  1  packed word available.
REQ-009 out_data  output  4*NIBBLES  packed word; first-accepted item in bits [3:0].
REQ-010 out_count  output  4  number of valid items in out_data, 1..NIBBLES.
REQ-011 out_ready  input  1  downstream consumes the word this cycle.
REQ-012 words  output  8  count of words emitted; wraps 255->0.

Function
REQ-013 An item SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-014 The block SHALL have states IDLE, FILL and EMIT.
REQ-015 IDLE SHALL go to FILL on the first rising edge after reset deasserts.
REQ-016 in_ready SHALL be registered, and SHALL be 1 in FILL and 0 in IDLE and EMIT.
REQ-017 The k-th accepted item (k from 0) SHALL be written to bits [4k+3:4k]; unfilled bits SHALL read 0.
REQ-018 Fill counter cnt SHALL be 0..NIBBLES-1 and SHALL increment per accept.
REQ-019 An accept with cnt=NIBBLES-1 SHALL go to EMIT with out_count=NIBBLES, one cycle after the final accept.
REQ-020 flush=1 in FILL with cnt>0 and no accept SHALL go to EMIT with out_count=cnt.
REQ-021 flush=1 with an accept in the same cycle SHALL include that item, then go to EMIT with out_count=cnt+1.
REQ-022 flush=1 in FILL with cnt=0 and no accept SHALL be ignored.
REQ-023 flush SHALL be ignored in IDLE and EMIT.
REQ-024 In EMIT, out_valid SHALL be 1, and out_data and out_count SHALL be held stable until out_ready=1.
REQ-025 EMIT with out_ready=1 SHALL return to FILL, clear cnt, clear the data register to 0, and increment words.
REQ-026 out_valid SHALL be 0 in IDLE and FILL; out_ready SHALL be ignored there.
REQ-027 Steady-state throughput SHALL be one full word per NIBBLES+1 cycles.

Reset
REQ-028 Asserting reset (0) SHALL immediately force state=IDLE, cnt=0, in_ready=0, out_valid=0, out_data=0, out_count=0, words=0.
REQ-029 Reset mid-fill or mid-EMIT SHALL discard the partial or pending word, with no output.
REQ-030 No item SHALL be accepted while reset is asserted.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/FILL/EMIT), item width constant 4 and the default NIBBLES.
REQ-032 The block SHALL be a single module with no sub-module.
REQ-033 The block SHALL be composable directly downstream of the 2-entry queue (deq_valid->in_valid, dout->in_data, in_ready->deq).

Verification
REQ-034 Scenario: release reset, then present 1,2,3,4 on consecutive cycles -> in_ready rises one cycle after release; the cycle after the 4th accept, out_valid=1, out_data=0x4321, out_count=4.
REQ-035 Scenario: hold out_ready=0 for 5 cycles in EMIT with in_valid=1 -> out_data stays 0x4321, in_ready=0, no item accepted; out_ready=1 -> words=1 and in_ready=1 the next cycle.
REQ-036 Scenario: accept 0xA, 0xB, then flush with no accept -> out_data=0x00BA, out_count=2.
REQ-037 Scenario: accept 0x5 with flush=1 in the same cycle at cnt=0 -> out_data=0x0005, out_count=1; flush alone at cnt=0 -> no EMIT.
REQ-038 Scenario: assert reset after 3 accepts, release, then accept 7,8,9,A -> only 0xA987 is emitted, words=1.
REQ-039 Scenario: queue plus packer, 256 full words -> words wraps to 0, no items lost or duplicated.
